gate_op_arbiter: RTL and testbench

- Shares one registered two-operand logic unit (AND/OR/XOR/NAND) among N requesters.
- Round-robin arbitration, one-cycle grant pulse, operand capture and a registered result with a valid/ready response handshake.
- Sits between the lab's per-user stimulus blocks and the common gate datapath, so a single logic unit serves several consumers.

---
 rtl/gate_op_arbiter.sv | 148 ++++++++++++++
 tb/tb_gate_op_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one registered AND/OR/XOR/NAND unit among N requesters.
// Define GATE_ARB_FIXED_PRIO_EN to freeze the pointer at 0 (requester 0 has absolute priority).
module gate_op_arbiter #(
  parameter int N   = 4,
  parameter int W   = 4,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [2*N-1:0]   op_in,
  input  logic [W*N-1:0]   a_in,
  input  logic [W*N-1:0]   b_in,
  output logic [N-1:0]     gnt,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_y,
  output logic [IDW-1:0]   res_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   win_q;
  logic [1:0]       op_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [N-1:0]     gnt_q;
  logic             busy_q;
  logic             valid_q;
  logic [W-1:0]     y_q;
  logic [IDW-1:0]   id_q;

  logic [IDW-1:0]   win_d;
  logic [IDW-1:0]   ptr_d;
  logic [W-1:0]     y_d;
  logic [N-1:0]     onehot_d;

  logic [1:0]       op_s [N];
  logic [W-1:0]     a_s  [N];
  logic [W-1:0]     b_s  [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign op_s[gi] = op_in[2*gi +: 2];
      assign a_s[gi]  = a_in[W*gi +: W];
      assign b_s[gi]  = b_in[W*gi +: W];
    end
  endgenerate

  // Scan offsets from farthest to nearest so the closest active requester after ptr wins.
  always_comb begin
    win_d = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr_q) + k) % N;
      if (req[idx]) win_d = IDW'(idx);
    end
  end

  always_comb begin
    onehot_d = '0;
    onehot_d[win_d] = 1'b1;
  end

  always_comb begin
    y_d = '0;
    case (op_q)
      2'b00:   y_d = a_q & b_q;
      2'b01:   y_d = a_q | b_q;
      2'b10:   y_d = a_q ^ b_q;
      default: y_d = ~(a_q & b_q);
    endcase
  end

`ifdef GATE_ARB_FIXED_PRIO_EN
  assign ptr_d = '0;
`else
  assign ptr_d = (win_q == IDW'(N - 1)) ? '0 : win_q + IDW'(1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      y_q     <= '0;
      id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          gnt_q <= '0;
          if (|req) begin
            op_q    <= op_s[win_d];
            a_q     <= a_s[win_d];
            b_q     <= b_s[win_d];
            win_q   <= win_d;
            gnt_q   <= onehot_d;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          gnt_q   <= '0;
          y_q     <= y_d;
          id_q    <= win_q;
          valid_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          // Result and id hold until accepted; req is not looked at here.
          if (res_ready) begin
            valid_q <= 1'b0;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign res_valid = valid_q;
  assign res_y     = y_q;
  assign res_id    = id_q;

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Scoreboard bench for gate_op_arbiter: expected grants/results are queued, monitors pop and compare.
module tb_gate_op_arbiter;
  localparam int N = 4, W = 4, IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [2*N-1:0] op_in;
  logic [W*N-1:0] a_in, b_in;
  logic [N-1:0]   gnt;
  logic           busy, res_valid, res_ready;
  logic [W-1:0]   res_y;
  logic [IDW-1:0] res_id;

  int vectors = 0;
  int errors  = 0;

  logic [N-1:0] gq [$];
  logic [5:0]   rq [$];

  gate_op_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .op_in(op_in), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_id(res_id)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (gnt != '0) begin
        logic [N-1:0] eg;
        vectors++;
        if (gq.size() == 0) begin
          errors++;
          $display("FAIL gnt_unexpected got=%b required=none", gnt);
        end else begin
          eg = gq.pop_front();
          if (gnt !== eg) begin
            errors++;
            $display("FAIL gnt got=%b required=%b", gnt, eg);
          end else $display("gnt %b ok", gnt);
        end
      end
      if (res_valid && res_ready) begin
        logic [5:0] er;
        vectors++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL result_unexpected got id=%0d y=%b required=none", res_id, res_y);
        end else begin
          er = rq.pop_front();
          if ({res_id, res_y} !== er) begin
            errors++;
            $display("FAIL result got id=%0d y=%b required id=%0d y=%b", res_id, res_y, er[5:4], er[3:0]);
          end else $display("result id=%0d y=%b ok", res_id, res_y);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end else $display("%s = %0h ok", name, got);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      if (!busy) done = 1;
    end
    if (!done) begin
      vectors++; errors++;
      $display("FAIL idle_timeout got busy=1 required busy=0");
    end
  endtask

  task automatic wait_valid();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (res_valid) done = 1;
    end
    if (!done) begin
      vectors++; errors++;
      $display("FAIL valid_timeout got res_valid=0 required res_valid=1");
    end
  endtask

  task automatic wait_grants(input int n);
    int cnt = 0;
    for (int i = 0; i < 30 && cnt < n; i++) begin
      @(negedge clk);
      if (gnt != '0) cnt++;
    end
    if (cnt < n) begin
      vectors++; errors++;
      $display("FAIL grant_timeout got=%0d grants required=%0d", cnt, n);
    end
  endtask

  task automatic do_single(input logic [N-1:0] r, input logic [N-1:0] eg,
                           input logic [1:0] eid, input logic [3:0] ey);
    gq.push_back(eg);
    rq.push_back({eid, ey});
    @(posedge clk); #1 req = r;
    @(posedge clk); #1 req = '0;
    wait_idle();
  endtask

  initial begin
    rst = 1'b1; req = '0; res_ready = 1'b1;
    op_in = 8'b01_01_00_01;
    a_in  = 16'hFFCF;
    b_in  = 16'hFFAF;
    #12;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_y_id", 32'({res_id, res_y}), 0);
    @(negedge clk); rst = 1'b0;

    // Reset while a result is pending: result lost, ptr back to 0.
    res_ready = 1'b0;
    gq.push_back(4'b0100);
    @(posedge clk); #1 req = 4'b0100;
    @(posedge clk); #1 req = '0;
    wait_valid();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(res_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    #2 rst = 1'b0;
    res_ready = 1'b1;
    do_single(4'b1010, 4'b0010, 2'd1, 4'b1000);

    // One operation of each type from requester 1.
    op_in[3:2] = 2'b01; do_single(4'b0010, 4'b0010, 2'd1, 4'b1110);
    op_in[3:2] = 2'b10; do_single(4'b0010, 4'b0010, 2'd1, 4'b0110);
    op_in[3:2] = 2'b11; do_single(4'b0010, 4'b0010, 2'd1, 4'b0111);

    @(negedge clk); rst = 1'b1;
    #2 rst = 1'b0;

    // All four requesting: rotation and 3-cycle grant spacing.
    op_in = 8'b11_10_01_00;
    a_in  = 16'hA63C;
    b_in  = 16'h535A;
`ifdef GATE_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++) begin gq.push_back(4'b0001); rq.push_back({2'd0, 4'h8}); end
`else
    gq.push_back(4'b0001); rq.push_back({2'd0, 4'h8});
    gq.push_back(4'b0010); rq.push_back({2'd1, 4'h7});
    gq.push_back(4'b0100); rq.push_back({2'd2, 4'h5});
    gq.push_back(4'b1000); rq.push_back({2'd3, 4'hF});
    gq.push_back(4'b0001); rq.push_back({2'd0, 4'h8});
`endif
    @(posedge clk); #1 req = 4'b1111;
    wait_grants(1);
    for (int g = 0; g < 4; g++) begin
      repeat (2) begin
        @(negedge clk);
        chk("rr_gap_gnt", 32'(gnt), 0);
      end
      @(negedge clk);
      chk("rr_gnt_present", 32'(gnt != '0), 1);
    end
    req = '0;
    wait_idle();

    // Backpressure: result holds, operand changes and req[3] ignored.
    res_ready = 1'b0;
    gq.push_back(4'b0010); rq.push_back({2'd1, 4'h7});
    @(posedge clk); #1 req = 4'b0010;
    @(posedge clk); #1 req = '0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      a_in = ~a_in;
      b_in = b_in ^ 16'h1234;
      req[3] = 1'b1;
      @(negedge clk);
      chk("bp_valid", 32'(res_valid), 1);
      chk("bp_y", 32'(res_y), 32'h7);
      chk("bp_id", 32'(res_id), 1);
      chk("bp_gnt", 32'(gnt), 0);
    end
    gq.push_back(4'b1000); rq.push_back({2'd3, 4'hB});
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_busy", 32'(busy), 0);
    chk("bp_release_gnt", 32'(gnt), 0);
    @(posedge clk); #1;
    chk("bp_next_gnt", 32'(gnt), 32'b1000);
    req = '0;
    wait_idle();

    // Pointer wrap after serving requester 3.
    a_in = 16'hA63C;
    b_in = 16'h535A;
`ifdef GATE_ARB_FIXED_PRIO_EN
    gq.push_back(4'b0001); rq.push_back({2'd0, 4'h8});
    gq.push_back(4'b0001); rq.push_back({2'd0, 4'h8});
`else
    gq.push_back(4'b0001); rq.push_back({2'd0, 4'h8});
    gq.push_back(4'b1000); rq.push_back({2'd3, 4'hF});
`endif
    @(posedge clk); #1 req = 4'b1001;
    wait_grants(2);
    req = '0;
    wait_idle();

    repeat (3) @(negedge clk);
    chk("queues_drained", 32'(gq.size() + rq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
